// File: rtl/instruction_issuer.sv
// instruction_issuer: initiator side of the Datapath start/finished handshake.
// Accepts one host command at a time (NOP/PLOT/READ/WRITE), packs it into a
// single instruction word, issues it to Datapath, waits for completion and
// returns exactly one response per command.
// Optional build macro: ISSUER_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a command with rsp_error=1 after TIMEOUT_CYCLES cycles in WAIT.
module instruction_issuer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 4,
  parameter int RESULT_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [7:0]                   cmd_x,
  input  logic [6:0]                   cmd_y,
  input  logic [2:0]                   cmd_colour,
  input  logic                         cmd_plot,
  input  logic [15:0]                  cmd_addr,
  input  logic [11:0]                  cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [RESULT_WIDTH-1:0]      rsp_data,
  output logic                         rsp_error,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  input  logic                         dp_finished,
  input  logic [RESULT_WIDTH-1:0]      dp_result
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_PLOT  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // The field layout needs 28 payload bits below the opcode.
  if (INSTRUCTION_WIDTH < OPCODE_WIDTH + 28 || OPCODE_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("instruction_issuer: illegal parameter combination");
  end

  // Pack a host command into one instruction word; every unused bit is zero.
  function automatic logic [INSTRUCTION_WIDTH-1:0] build_word(
    input logic [1:0]  op,
    input logic [7:0]  x,
    input logic [6:0]  y,
    input logic [2:0]  colour,
    input logic        plot,
    input logic [15:0] addr,
    input logic [11:0] data
  );
    logic [INSTRUCTION_WIDTH-1:0] w;
    w = '0;
    w[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_WIDTH'(op);
    case (op)
      OP_PLOT: begin
        w[7:0]   = x;
        w[14:8]  = y;
        w[17:15] = colour;
        w[18]    = plot;
      end
      OP_READ: begin
        w[15:0] = addr;
      end
      OP_WRITE: begin
        w[15:0]  = addr;
        w[27:16] = data;
      end
      default: begin
        // NOP carries the opcode field only
        w[15:0] = w[15:0];
      end
    endcase
    return w;
  endfunction

  state_t                         state_q, state_d;
  logic [1:0]                     op_q, op_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic                           start_q, start_d;
  logic                           cmd_ready_q, cmd_ready_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [RESULT_WIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic                           rsp_error_q, rsp_error_d;
  logic                           timeout_s;

`ifdef ISSUER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog next value: cleared while issuing (i.e. on WAIT entry), counts each WAIT cycle.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_ISSUE) begin
      wd_d = '0;
    end else if (state_q == S_WAIT && wd_q != WD_LAST) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout_s = (state_q == S_WAIT) && (wd_q == WD_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic for the issue handshake FSM.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    instr_d     = instr_q;
    start_d     = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_ISSUE;
          op_d    = cmd_op;
          instr_d = build_word(cmd_op, cmd_x, cmd_y, cmd_colour, cmd_plot, cmd_addr, cmd_data);
          start_d = dp_finished;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Only offer start while Datapath reports idle; the handshake completes
        // on an edge where both are high.
        if (start_q && dp_finished) begin
          state_d = S_WAIT;
          start_d = 1'b0;
        end else begin
          start_d = dp_finished;
        end
      end
      S_WAIT: begin
        if (dp_finished) begin
          state_d     = S_RESP;
          rsp_data_d  = (op_q == OP_READ) ? dp_result : '0;
          rsp_error_d = 1'b0;
        end else if (timeout_s) begin
          state_d     = S_RESP;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      instr_q     <= '0;
      start_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      instr_q     <= instr_d;
      start_q     <= start_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_error      = rsp_error_q;
  assign dp_start       = start_q;
  assign dp_instruction = instr_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Testbench for instruction_issuer: directed commands against a small
// Datapath model; expected words and responses go into scoreboard queues and
// a monitor compares them whenever the DUT issues or responds.
module tb_instruction_issuer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [2:0]  cmd_colour;
  logic        cmd_plot;
  logic [15:0] cmd_addr;
  logic [11:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_data;
  logic        rsp_error;
  logic        dp_start;
  logic [31:0] dp_instruction;
  logic        dp_finished;
  logic [11:0] dp_result;

  logic stall;
  logic hang;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_word_q[$];
  logic [12:0] exp_rsp_q[$];

  instruction_issuer #(
    .INSTRUCTION_WIDTH(32),
    .OPCODE_WIDTH(4),
    .RESULT_WIDTH(12),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_colour(cmd_colour),
    .cmd_plot(cmd_plot),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .dp_start(dp_start),
    .dp_instruction(dp_instruction),
    .dp_finished(dp_finished),
    .dp_result(dp_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Datapath model ----------------
  logic        busy_r;
  int          cnt_r;
  logic [31:0] instr_r;
  logic [11:0] result_r;
  logic [11:0] mem [0:255];

  assign dp_finished = !busy_r && !stall;
  assign dp_result   = result_r;

  function automatic int latency(input logic [3:0] op);
    case (op)
      4'd0:    return 1;
      4'd1:    return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      busy_r   <= 1'b0;
      cnt_r    <= 0;
      result_r <= 12'h000;
    end else if (dp_start && dp_finished) begin
      busy_r  <= 1'b1;
      instr_r <= dp_instruction;
      cnt_r   <= latency(dp_instruction[31:28]);
    end else if (busy_r && !hang) begin
      if (cnt_r <= 1) begin
        busy_r <= 1'b0;
        if (instr_r[31:28] == 4'd3) begin
          mem[instr_r[7:0]] <= instr_r[27:16];
          result_r <= 12'hFFF;
        end else if (instr_r[31:28] == 4'd2) begin
          result_r <= mem[instr_r[7:0]];
        end else begin
          result_r <= 12'hFFF;
        end
      end else begin
        cnt_r <= cnt_r - 1;
      end
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [31:0] ew;
    logic [12:0] er;
    if (!reset) begin
      if (dp_start && dp_finished) begin
        if (exp_word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got word 0x%0h expected no issue", dp_instruction);
        end else begin
          ew = exp_word_q.pop_front();
          chk("dp_instruction", dp_instruction, ew);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got data 0x%0h err %0d expected none", rsp_data, rsp_error);
        end else begin
          er = exp_rsp_q.pop_front();
          chk("rsp_data", {20'd0, rsp_data}, {20'd0, er[11:0]});
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, er[12]});
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] col, input logic pl, input logic [15:0] addr,
                      input logic [11:0] data, input logic [31:0] word, input bit has_rsp,
                      input logic [11:0] rdata, input logic rerr);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    exp_word_q.push_back(word);
    if (has_rsp) exp_rsp_q.push_back({rerr, rdata});
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_x      = x;
    cmd_y      = y;
    cmd_colour = col;
    cmd_plot   = pl;
    cmd_addr   = addr;
    cmd_data   = data;
    @(posedge clock); #1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_x      = 8'($urandom);
    cmd_y      = 7'($urandom);
    cmd_colour = 3'($urandom);
    cmd_plot   = 1'($urandom);
    cmd_addr   = 16'($urandom);
    cmd_data   = 12'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || !cmd_ready) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, exp_rsp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int starts;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_x = 8'd0; cmd_y = 7'd0; cmd_colour = 3'd0;
    cmd_plot = 1'b0; cmd_addr = 16'd0; cmd_data = 12'd0;
    rsp_ready = 1'b1; stall = 1'b0; hang = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", {20'd0, rsp_data}, 32'd0);
    chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset_dp_start", {31'd0, dp_start}, 32'd0);
    chk("reset_dp_instruction", dp_instruction, 32'd0);
    reset = 1'b0;

    // PLOT: one start pulse, single RESP cycle with rsp_ready high
    send(2'd1, 8'h12, 7'h34, 3'd5, 1'b1, 16'hFFFF, 12'hFFF, 32'h1006B412, 1'b1, 12'h000, 1'b0);
    starts = 0; n = 0;
    while (!rsp_valid && n < 20) begin
      if (dp_start) starts++;
      @(posedge clock); #1;
      n++;
    end
    chk("plot_start_pulses", starts, 1);
    chk("plot_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clock); #1;
    chk("plot_one_resp_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("plot_ready_after_resp", {31'd0, cmd_ready}, 32'd1);

    // WRITE then READ back, unused fields driven with junk
    send(2'd3, 8'hFF, 7'h7F, 3'd7, 1'b1, 16'h00A5, 12'hABC, 32'h3ABC00A5, 1'b1, 12'h000, 1'b0);
    send(2'd2, 8'hFF, 7'h7F, 3'd7, 1'b1, 16'h00A5, 12'hFFF, 32'h200000A5, 1'b1, 12'hABC, 1'b0);
    send(2'd3, 8'h00, 7'h00, 3'd0, 1'b0, 16'h1234, 12'h5A5, 32'h35A51234, 1'b1, 12'h000, 1'b0);
    send(2'd2, 8'h00, 7'h00, 3'd0, 1'b0, 16'h1234, 12'h000, 32'h20001234, 1'b1, 12'h5A5, 1'b0);
    // PLOT field extremes with plot bit clear
    send(2'd1, 8'hFF, 7'h7F, 3'd7, 1'b0, 16'hFFFF, 12'hFFF, 32'h1003FFFF, 1'b1, 12'h000, 1'b0);
    wait_idle("rw_plot_drain");

    // NOP with rsp_ready held low; cmd_valid during RESP must be ignored
    rsp_ready = 1'b0;
    send(2'd0, 8'hAA, 7'h55, 3'd3, 1'b1, 16'hBEEF, 12'h123, 32'h00000000, 1'b1, 12'h000, 1'b0);
    n = 0;
    while (!rsp_valid && n < 4) begin
      @(posedge clock); #1;
      n++;
    end
    chk("nop_rsp_within_4", {31'd0, rsp_valid}, 32'd1);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    repeat (5) begin
      @(posedge clock); #1;
      chk("nop_hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("nop_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("nop_hold_rsp_data", {20'd0, rsp_data}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("nop_drain");

    // Datapath busy at accept: start held off, then exactly one pulse
    stall = 1'b1;
    send(2'd1, 8'h01, 7'h02, 3'd3, 1'b1, 16'h0000, 12'h000, 32'h10058201, 1'b1, 12'h000, 1'b0);
    repeat (4) begin
      chk("stall_no_start", {31'd0, dp_start}, 32'd0);
      @(posedge clock); #1;
    end
    stall = 1'b0;
    starts = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (dp_start) starts++;
    end
    chk("stall_start_pulses", starts, 1);
    wait_idle("stall_drain");

    // Reset during WAIT abandons the command
    hang = 1'b1;
    send(2'd2, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0010, 12'h000, 32'h20000010, 1'b0, 12'h000, 1'b0);
    n = 0;
    while (!dp_start && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_dp_start", {31'd0, dp_start}, 32'd0);
    chk("abort_dp_instruction", dp_instruction, 32'd0);
    reset = 1'b0;
    hang = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    send(2'd0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0000, 12'h000, 32'h00000000, 1'b1, 12'h000, 1'b0);
    wait_idle("recover_drain");

    // Datapath never finishes after the start pulse
    hang = 1'b1;
`ifdef ISSUER_TIMEOUT_EN
    send(2'd0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0000, 12'h000, 32'h00000000, 1'b1, 12'h000, 1'b1);
`else
    send(2'd0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0000, 12'h000, 32'h00000000, 1'b0, 12'h000, 1'b0);
`endif
    n = 0;
    while (!dp_start && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    chk("hang_start_seen", {31'd0, dp_start}, 32'd1);
    repeat (8) @(posedge clock);
    #1;
    chk("hang_not_early", {31'd0, rsp_valid}, 32'd0);
    @(posedge clock); #1;
`ifdef ISSUER_TIMEOUT_EN
    chk("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("timeout_rsp_error", {31'd0, rsp_error}, 32'd1);
    @(posedge clock); #1;
`else
    repeat (10) @(posedge clock);
    #1;
    chk("no_timeout_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("no_timeout_cmd_ready", {31'd0, cmd_ready}, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    hang = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    chk("word_queue_empty", exp_word_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
